// File: rtl/video_timing_gen.sv
// Parametrised progressive raster timing generator: coordinates, active flag, sync pulses and line/frame strobes.
// Optional frame counter built when VTG_FRAME_CNT_EN is defined; otherwise frame_cnt is tied to zero.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned CW       = 12
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          sol,
    output logic          eol,
    output logic          sof,
    output logic          eof,
    output logic [15:0]   frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HSS     = H_ACTIVE + H_FP;
    localparam int unsigned HSE     = HSS + H_SYNC;
    localparam int unsigned VSS     = V_ACTIVE + V_FP;
    localparam int unsigned VSE     = VSS + V_SYNC;

    localparam logic [CW-1:0] X_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(V_TOTAL - 1);
    localparam logic          HS_ON  = 1'(HS_POL);
    localparam logic          VS_ON  = 1'(VS_POL);

    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;
    logic          active_nxt;
    logic          hsync_nxt;
    logic          vsync_nxt;
    logic          sol_nxt;
    logic          eol_nxt;
    logic          sof_nxt;
    logic          eof_nxt;

    // Next raster position and the flags that describe it, so flags never lag coordinates
    always_comb begin
        x_nxt = x + CW'(1);
        y_nxt = y;
        if (x == X_LAST) begin
            x_nxt = '0;
            y_nxt = (y == Y_LAST) ? '0 : y + CW'(1);
        end
        active_nxt = (x_nxt < CW'(H_ACTIVE)) && (y_nxt < CW'(V_ACTIVE));
        hsync_nxt  = ((x_nxt >= CW'(HSS)) && (x_nxt < CW'(HSE))) ? HS_ON : ~HS_ON;
        vsync_nxt  = ((y_nxt >= CW'(VSS)) && (y_nxt < CW'(VSE))) ? VS_ON : ~VS_ON;
        sol_nxt    = (x_nxt == '0);
        eol_nxt    = (x_nxt == X_LAST);
        sof_nxt    = sol_nxt && (y_nxt == '0);
        eof_nxt    = eol_nxt && (y_nxt == Y_LAST);
    end

    // Reset parks at the last frame position with all strobes low
    always_ff @(posedge pclk) begin
        if (rst) begin
            x      <= X_LAST;
            y      <= Y_LAST;
            active <= 1'b0;
            hsync  <= ~HS_ON;
            vsync  <= ~VS_ON;
            sol    <= 1'b0;
            eol    <= 1'b0;
            sof    <= 1'b0;
            eof    <= 1'b0;
        end else if (en) begin
            x      <= x_nxt;
            y      <= y_nxt;
            active <= active_nxt;
            hsync  <= hsync_nxt;
            vsync  <= vsync_nxt;
            sol    <= sol_nxt;
            eol    <= eol_nxt;
            sof    <= sof_nxt;
            eof    <= eof_nxt;
        end
    end

`ifdef VTG_FRAME_CNT_EN
    // Reset value of all-ones makes the first frame after reset read zero
    always_ff @(posedge pclk) begin
        if (rst) begin
            frame_cnt <= 16'hFFFF;
        end else if (en && sof_nxt) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`else
    assign frame_cnt = 16'h0000;
`endif

endmodule
